// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external ALU between two requesters
// Latches the winner's operands, registers the ALU result, returns it under valid/ack.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int FW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_func,
    output logic             gnt0,
    output logic             rsp0_valid,
    input  logic             rsp0_ack,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_func,
    output logic             gnt1,
    output logic             rsp1_valid,
    input  logic             rsp1_ack,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_func,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_owner;
    logic             r_last_gnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [FW-1:0]    r_alu_func;
    logic [WIDTH-1:0] r_rsp_data;
    logic [15:0]      r_op_count;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_ack;

    // Only the current owner's ack can close out DONE.
    assign w_ack = r_owner ? rsp1_ack : rsp0_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (req0_valid && (!req1_valid || r_last_gnt)) begin
                    w_gnt0 = 1'b1;
                end else if (req1_valid) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next = EXEC;
                end
            end
            EXEC: w_next = DONE;
            DONE: begin
                if (w_ack) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_func <= '0;
            r_rsp_data <= '0;
            r_op_count <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_alu_a    <= w_gnt1 ? req1_a : req0_a;
                r_alu_b    <= w_gnt1 ? req1_b : req0_b;
                r_alu_func <= w_gnt1 ? req1_func : req0_func;
                r_owner    <= w_gnt1;
                r_last_gnt <= w_gnt1;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= alu_out;
            end
            if (r_state == DONE && w_ack) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rsp0_valid = (r_state == DONE) && !r_owner;
    assign rsp1_valid = (r_state == DONE) && r_owner;
    assign rsp_data   = r_rsp_data;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_func   = r_alu_func;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule
